// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PCF, single-entry fetch buffer and IF/ID register.
// A fetched word is either delivered straight into IF/ID, or parked in the
// buffer (state HOLD) while the hazard unit stalls, so memory is not re-read.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             PCSrcD,
    input  logic [31:0]      PCBranchD,
    output logic [31:0]      ImemAddr,
    output logic             ImemReq,
    input  logic             ImemReady,
    input  logic [31:0]      ImemRdata,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus4D,
    output logic             ValidD,
    output logic [CNT_W-1:0] FetchCount,
    output logic [CNT_W-1:0] BubbleCount
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      PC_MASK = 32'hFFFF_FFFC;

    state_t           r_state;
    logic [31:0]      r_pcf;
    logic [31:0]      r_buf_instr;
    logic [31:0]      r_instr_d;
    logic [31:0]      r_pcp4_d;
    logic             r_valid_d;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    state_t           w_state_nxt;
    logic [31:0]      w_pcf_nxt;
    logic [31:0]      w_buf_instr_nxt;
    logic [31:0]      w_instr_d_nxt;
    logic [31:0]      w_pcp4_d_nxt;
    logic             w_valid_d_nxt;
    logic [CNT_W-1:0] w_fetch_cnt_nxt;
    logic [CNT_W-1:0] w_bubble_cnt_nxt;
    logic             w_redirect;
    logic             w_advance;
    logic             w_load_valid;
    logic             w_load_bubble;
    logic [31:0]      w_deliver_word;
    logic [31:0]      w_pc_plus4;

    assign w_redirect = PCSrcD & ~StallD;
    assign w_advance  = ~StallF & ~StallD;
    assign w_pc_plus4 = r_pcf + 32'd4;

    // Next-state, PC, buffer and IF/ID selection; redirect wins over all else.
    always_comb begin
        w_state_nxt      = r_state;
        w_pcf_nxt        = r_pcf;
        w_buf_instr_nxt  = r_buf_instr;
        w_load_valid     = 1'b0;
        w_load_bubble    = 1'b0;
        w_deliver_word   = ImemRdata;
        w_instr_d_nxt    = r_instr_d;
        w_pcp4_d_nxt     = r_pcp4_d;
        w_valid_d_nxt    = r_valid_d;
        w_fetch_cnt_nxt  = r_fetch_cnt;
        w_bubble_cnt_nxt = r_bubble_cnt;

        if (w_redirect) begin
            w_pcf_nxt       = PCBranchD & PC_MASK;
            w_state_nxt     = ST_REQ;
            w_buf_instr_nxt = 32'h0000_0000;
            w_load_bubble   = 1'b1;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (ImemReady) begin
                        if (w_advance) begin
                            w_load_valid   = 1'b1;
                            w_deliver_word = ImemRdata;
                            w_pcf_nxt      = w_pc_plus4;
                        end else begin
                            // Park the word; the address stays put until release.
                            w_buf_instr_nxt = ImemRdata;
                            w_state_nxt     = ST_HOLD;
                            w_load_bubble   = ~StallD;
                        end
                    end else begin
                        w_load_bubble = ~StallD;
                    end
                end
                ST_HOLD: begin
                    if (w_advance) begin
                        w_load_valid   = 1'b1;
                        w_deliver_word = r_buf_instr;
                        w_pcf_nxt      = w_pc_plus4;
                        w_state_nxt    = ST_REQ;
                    end else begin
                        w_load_bubble = ~StallD;
                    end
                end
                default: begin
                    w_state_nxt = ST_REQ;
                end
            endcase
        end

        if (w_load_valid) begin
            w_instr_d_nxt = w_deliver_word;
            w_pcp4_d_nxt  = w_pc_plus4;
            w_valid_d_nxt = 1'b1;
        end else if (w_load_bubble) begin
            w_instr_d_nxt = 32'h0000_0000;
            w_pcp4_d_nxt  = 32'h0000_0000;
            w_valid_d_nxt = 1'b0;
        end else begin
            w_valid_d_nxt = r_valid_d;
        end

        if (w_load_valid && (r_fetch_cnt != CNT_MAX)) begin
            w_fetch_cnt_nxt = r_fetch_cnt + CNT_ONE;
        end else begin
            w_fetch_cnt_nxt = r_fetch_cnt;
        end

        if (w_load_bubble && (r_bubble_cnt != CNT_MAX)) begin
            w_bubble_cnt_nxt = r_bubble_cnt + CNT_ONE;
        end else begin
            w_bubble_cnt_nxt = r_bubble_cnt;
        end
    end

    // State register with synchronous active-low reset taking priority.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state      <= ST_REQ;
            r_pcf        <= RESET_PC & PC_MASK;
            r_buf_instr  <= 32'h0000_0000;
            r_instr_d    <= 32'h0000_0000;
            r_pcp4_d     <= 32'h0000_0000;
            r_valid_d    <= 1'b0;
            r_fetch_cnt  <= {CNT_W{1'b0}};
            r_bubble_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_pcf        <= w_pcf_nxt;
            r_buf_instr  <= w_buf_instr_nxt;
            r_instr_d    <= w_instr_d_nxt;
            r_pcp4_d     <= w_pcp4_d_nxt;
            r_valid_d    <= w_valid_d_nxt;
            r_fetch_cnt  <= w_fetch_cnt_nxt;
            r_bubble_cnt <= w_bubble_cnt_nxt;
        end
    end

    assign ImemAddr    = r_pcf;
    assign ImemReq     = (r_state == ST_REQ);
    assign PCF         = r_pcf;
    assign InstrD      = r_instr_d;
    assign PCPlus4D    = r_pcp4_d;
    assign ValidD      = r_valid_d;
    assign FetchCount  = r_fetch_cnt;
    assign BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, corner sequences and random stimulus
// against a word-availability reference model of the fetch stage.
module tb_fetch_stage;

    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          Clk;
    logic          Rst_n;
    logic          StallF;
    logic          StallD;
    logic          PCSrcD;
    logic [31:0]   PCBranchD;
    logic [31:0]   ImemAddr;
    logic          ImemReq;
    logic          ImemReady;
    logic [31:0]   ImemRdata;
    logic [31:0]   PCF;
    logic [31:0]   InstrD;
    logic [31:0]   PCPlus4D;
    logic          ValidD;
    logic [CW-1:0] FetchCount;
    logic [CW-1:0] BubbleCount;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .StallF(StallF), .StallD(StallD),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .ImemAddr(ImemAddr),
        .ImemReq(ImemReq), .ImemReady(ImemReady), .ImemRdata(ImemRdata),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .FetchCount(FetchCount), .BubbleCount(BubbleCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory content is a fixed function of the address presented.
    always_comb ImemRdata = mem_word(ImemAddr);

    // Reference model: PC, an optionally parked word, IF/ID contents, counters.
    logic [31:0] m_pc, m_word, m_instr, m_pcp4;
    bit          m_holding, m_valid;
    int          m_fc, m_bc;

    task automatic model_step(input bit rst_n, input bit sf, input bit sd,
                              input bit ps, input logic [31:0] br, input bit rdy);
        bit          have;
        logic [31:0] w;
        have = m_holding || rdy;
        w    = m_holding ? m_word : mem_word(m_pc);
        if (!rst_n) begin
            m_pc = 32'h0; m_holding = 0; m_instr = 32'h0; m_pcp4 = 32'h0;
            m_valid = 0; m_fc = 0; m_bc = 0;
        end else if (ps && !sd) begin
            m_pc = {br[31:2], 2'b00}; m_holding = 0;
            m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 0;
            m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
        end else if (have && !sf && !sd) begin
            m_instr = w; m_pcp4 = m_pc + 32'd4; m_valid = 1;
            m_pc = m_pc + 32'd4; m_holding = 0;
            m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end else begin
            if (have) begin
                m_holding = 1; m_word = w;
            end
            if (!sd) begin
                m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 0;
                m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("model_PCF", PCF, m_pc);
        chk("model_ImemAddr", ImemAddr, m_pc);
        chk("model_ImemReq", {31'd0, ImemReq}, {31'd0, !m_holding});
        chk("model_InstrD", InstrD, m_instr);
        chk("model_PCPlus4D", PCPlus4D, m_pcp4);
        chk("model_ValidD", {31'd0, ValidD}, {31'd0, m_valid});
        chk("model_FetchCount", {28'd0, FetchCount}, 32'(m_fc));
        chk("model_BubbleCount", {28'd0, BubbleCount}, 32'(m_bc));
    endtask

    // One clock: apply inputs, advance model, sample #1 after the edge, compare.
    task automatic cycle(input bit rst_n, input bit sf, input bit sd,
                         input bit ps, input logic [31:0] br, input bit rdy);
        Rst_n = rst_n; StallF = sf; StallD = sd; PCSrcD = ps; PCBranchD = br; ImemReady = rdy;
        model_step(rst_n, sf, sd, ps, br, rdy);
        @(posedge Clk);
        #1;
        chk_model();
    endtask

    typedef struct {
        bit          rst_n, sf, sd, ps, rdy;
        logic [31:0] br;
        logic [31:0] e_pcf, e_instr, e_pcp4;
        bit          e_req, e_valid;
        int          e_fc, e_bc;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(bit rst_n, bit sf, bit sd, bit ps, logic [31:0] br, bit rdy,
                                logic [31:0] pcf, bit req, logic [31:0] ins,
                                logic [31:0] p4, bit v, int fc, int bc);
        vec_t r;
        r.rst_n = rst_n; r.sf = sf; r.sd = sd; r.ps = ps; r.br = br; r.rdy = rdy;
        r.e_pcf = pcf; r.e_req = req; r.e_instr = ins; r.e_pcp4 = p4;
        r.e_valid = v; r.e_fc = fc; r.e_bc = bc;
        return r;
    endfunction

    initial begin
        Rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
        PCBranchD = 32'h0; ImemReady = 1'b0;

        //               rst sf sd ps br            rdy  pcf          req instr              pcp4         v  fc bc
        tbl[0]  = mk(0, 0, 0, 0, 32'h0,  1, 32'h00, 1, 32'h0,            32'h00, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h04, 1, mem_word(32'h00), 32'h04, 1, 1, 0);
        tbl[2]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h08, 1, mem_word(32'h04), 32'h08, 1, 2, 0);
        tbl[3]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h0C, 1, mem_word(32'h08), 32'h0C, 1, 3, 0);
        tbl[4]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h10, 1, mem_word(32'h0C), 32'h10, 1, 4, 0);
        tbl[5]  = mk(1, 1, 1, 0, 32'h0,  1, 32'h10, 0, mem_word(32'h0C), 32'h10, 1, 4, 0);
        tbl[6]  = mk(1, 1, 1, 0, 32'h0,  0, 32'h10, 0, mem_word(32'h0C), 32'h10, 1, 4, 0);
        tbl[7]  = mk(1, 0, 0, 0, 32'h0,  0, 32'h14, 1, mem_word(32'h10), 32'h14, 1, 5, 0);
        tbl[8]  = mk(1, 0, 0, 0, 32'h0,  0, 32'h14, 1, 32'h0,            32'h00, 0, 5, 1);
        tbl[9]  = mk(1, 0, 0, 0, 32'h0,  0, 32'h14, 1, 32'h0,            32'h00, 0, 5, 2);
        tbl[10] = mk(1, 0, 0, 0, 32'h0,  0, 32'h14, 1, 32'h0,            32'h00, 0, 5, 3);
        tbl[11] = mk(1, 0, 0, 0, 32'h0,  1, 32'h18, 1, mem_word(32'h14), 32'h18, 1, 6, 3);
        tbl[12] = mk(1, 1, 1, 0, 32'h0,  1, 32'h18, 0, mem_word(32'h14), 32'h18, 1, 6, 3);
        tbl[13] = mk(1, 1, 1, 1, 32'h43, 0, 32'h18, 0, mem_word(32'h14), 32'h18, 1, 6, 3);
        tbl[14] = mk(1, 1, 0, 1, 32'h43, 0, 32'h40, 1, 32'h0,            32'h00, 0, 6, 4);
        tbl[15] = mk(1, 0, 0, 0, 32'h0,  1, 32'h44, 1, mem_word(32'h40), 32'h44, 1, 7, 4);
        tbl[16] = mk(1, 1, 1, 0, 32'h0,  1, 32'h44, 0, mem_word(32'h40), 32'h44, 1, 7, 4);
        tbl[17] = mk(1, 1, 0, 0, 32'h0,  0, 32'h44, 0, 32'h0,            32'h00, 0, 7, 5);
        tbl[18] = mk(1, 0, 0, 0, 32'h0,  0, 32'h48, 1, mem_word(32'h44), 32'h48, 1, 8, 5);

        @(negedge Clk);
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].rst_n, tbl[i].sf, tbl[i].sd, tbl[i].ps, tbl[i].br, tbl[i].rdy);
            chk($sformatf("tbl%0d_PCF", i), PCF, tbl[i].e_pcf);
            chk($sformatf("tbl%0d_ImemReq", i), {31'd0, ImemReq}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_InstrD", i), InstrD, tbl[i].e_instr);
            chk($sformatf("tbl%0d_PCPlus4D", i), PCPlus4D, tbl[i].e_pcp4);
            chk($sformatf("tbl%0d_ValidD", i), {31'd0, ValidD}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_FetchCount", i), {28'd0, FetchCount}, 32'(tbl[i].e_fc));
            chk($sformatf("tbl%0d_BubbleCount", i), {28'd0, BubbleCount}, 32'(tbl[i].e_bc));
        end

        // PC wrap-around: redirect to the last word, then fetch it.
        cycle(1, 0, 0, 1, 32'hFFFF_FFFF, 0);
        chk("wrap_redirect_PCF", PCF, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0, 32'h0, 1);
        chk("wrap_PCPlus4D", PCPlus4D, 32'h0000_0000);
        chk("wrap_PCF", PCF, 32'h0000_0000);
        chk("wrap_InstrD", InstrD, mem_word(32'hFFFF_FFFC));

        // Counter saturation: 20 deliveries then 20 bubbles with a 4-bit counter.
        cycle(0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 32'h0, 1);
        chk("sat_FetchCount", {28'd0, FetchCount}, 32'd15);
        chk("sat_PCF", PCF, 32'h0000_0050);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 32'h0, 0);
        chk("sat_BubbleCount", {28'd0, BubbleCount}, 32'd15);
        chk("sat_FetchCount_held", {28'd0, FetchCount}, 32'd15);

        // Reset asserted while holding a parked word.
        cycle(1, 1, 1, 0, 32'h0, 1);
        chk("rsthold_ImemReq", {31'd0, ImemReq}, 32'd0);
        cycle(0, 1, 1, 1, 32'h80, 1);
        chk("rsthold_PCF", PCF, 32'h0000_0000);
        chk("rsthold_ImemReq_after", {31'd0, ImemReq}, 32'd1);
        chk("rsthold_ValidD", {31'd0, ValidD}, 32'd0);
        chk("rsthold_FetchCount", {28'd0, FetchCount}, 32'd0);
        chk("rsthold_BubbleCount", {28'd0, BubbleCount}, 32'd0);
        cycle(1, 0, 0, 0, 32'h0, 1);
        chk("rsthold_first_InstrD", InstrD, mem_word(32'h0));

        // Random phase checked against the model every cycle.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  $urandom(),
                  ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register, directly upstream of the hazard unit.
- Holds PCF and issues instruction fetches over a ready-handshake memory port.
- Buffers a returned instruction while the hazard unit stalls fetch.
- Registers InstrD/PCPlus4D for decode; obeys StallF/StallD and branch redirects resolved in decode (PCSrcD/PCBranchD), and keeps delivery/bubble counters.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset (word aligned)
CNT_W  16  width of the saturating performance counters

Ports:
Clk  in  1  system clock, all state updates on rising edge
Rst_n  in  1  synchronous active-low reset
StallF  in  1  hold PCF / fetch buffer (from hazard unit)
StallD  in  1  hold IF/ID register (from hazard unit)
PCSrcD  in  1  branch taken, resolved in decode
PCBranchD  in  32  branch target from decode
ImemAddr  out  32  fetch address, equals PCF
ImemReq  out  1  fetch request, combinational from state
ImemReady  in  1  ImemRdata valid for the current ImemAddr this cycle
ImemRdata  in  32  instruction word
PCF  out  32  current fetch PC
InstrD  out  32  IF/ID instruction
PCPlus4D  out  32  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction (0 = bubble)
FetchCount  out  CNT_W  instructions delivered to IF/ID
BubbleCount  out  CNT_W  cycles a bubble was loaded into IF/ID

Behaviour:
- Interface: one clock Clk; reset Rst_n is synchronous, active-low.
- Reset (Rst_n=0 at edge):
  - PCF=RESET_PC; InstrD=0, PCPlus4D=0, ValidD=0.
  - Fetch buffer invalid; state=REQ; both counters=0.
  - Reset has priority over every other input, including mid-HOLD.
- Address and arithmetic:
  - ImemAddr=PCF.
  - PCF[1:0] always 0; PCBranchD[1:0] ignored.
  - PC+4 is 32-bit wrap-around: 32'hFFFF_FFFC+4 = 0.
- Handshake: no outstanding transactions. ImemReady qualifies data for the address presented in the same cycle. Changing the address implicitly cancels the request.
- Redirect:
  - Redirect = PCSrcD & !StallD. PCSrcD is ignored while StallD=1.
  - Redirect overrides everything else: PCF<=PCBranchD&~3; IF/ID loads bubble (InstrD=0, ValidD=0, PCPlus4D=0); fetch buffer discarded; state<=REQ.
  - Redirect applies even if StallF=1.
- State REQ (ImemReq=1), no redirect:
  - ImemReady & !StallF & !StallD: IF/ID <= {ImemRdata, PCF+4}, ValidD=1; PCF<=PCF+4; stay REQ.
  - ImemReady & (StallF | StallD): ImemRdata and PCF+4 captured into fetch buffer; PCF unchanged; go HOLD.
  - !ImemReady: PCF unchanged. IF/ID loads bubble if !StallD, holds if StallD.
- State HOLD (ImemReq=0), no redirect:
  - !StallF & !StallD: buffer -> IF/ID, ValidD=1; PCF<=PCF+4; go REQ.
  - Otherwise: buffer and PCF held. IF/ID holds if StallD, loads bubble if !StallD & StallF.
- IF/ID write rule: when StallD=1 and no redirect, IF/ID is never written.
- Counters:
  - FetchCount increments on every edge that loads ValidD=1.
  - BubbleCount increments on every edge that loads a bubble, redirect flushes included.
  - Both saturate at all-ones; not incremented during reset.
- Latency: memory ready in cycle N -> instruction visible on InstrD in cycle N+1. Back-to-back ready, no stalls -> one instruction per cycle.

Test Plan:
- Reset then ImemReady=1 held for 4 cycles, no stalls -> PCF 0,4,8,C,10; InstrD follows ImemRdata one cycle later; ValidD=1 from cycle 2; FetchCount=4.
- ImemReady=0 for 3 cycles at PCF=8 -> PCF stays 8; 3 bubbles (ValidD=0, InstrD=0); BubbleCount=3; resumes at 8 when ready.
- Ready at PCF=0x10 with StallF=StallD=1 for 2 cycles -> HOLD, ImemReq=0, IF/ID unchanged; on release InstrD=buffered word, PCPlus4D=0x14, PCF=0x14.
- PCSrcD=1, PCBranchD=0x43 while in HOLD -> PCF=0x40, buffer dropped, ValidD=0 next cycle, ImemReq=1; same stimulus with StallD=1 -> PCSrcD ignored.
- PCF=32'hFFFF_FFFC with ready -> PCPlus4D=0, PCF=0; counters preloaded to all-ones stay saturated.
- Rst_n=0 asserted mid-HOLD -> next edge PCF=RESET_PC, ValidD=0, counters 0, state REQ.
